mtm_alu_deserializer: RTL and testbench

- Serial receive front end of the mtm ALU: samples `sin`, decodes 11-bit packets and assembles B, A and CTL.
- Checks packet count, CRC and opcode, then hands the ALU core one validated operand set, or exactly one error indication, per CTL packet.
- Sits between the chip `sin` pin and the ALU core. It is the receiving end of the bench's `send_byte` / `send_calculation_data` stream.

---
 rtl/mtm_alu_deserializer.sv | 167 ++++++++++++++++
 tb/tb_mtm_alu_deserializer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_deserializer.sv
// Serial receive front end of the mtm ALU: decodes 11-bit sin packets, assembles B/A/OP and
// validates count, CRC-4 and opcode. Optional `MTM_DESER_SIN_SYNC_EN adds a 2-flop sin synchronizer.
module mtm_alu_deserializer #(
  parameter int N_DATA = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  op,
  output logic        valid,
  output logic        err_data,
  output logic        err_crc,
  output logic        err_op,
  output logic        err_frame
);

  typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD, STOP} state_e;

  localparam int            CW       = $clog2(N_DATA + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(N_DATA);
  localparam logic [CW-1:0] CNT_SAT  = CW'(N_DATA + 1);

  logic sin_s;

`ifdef MTM_DESER_SIN_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], sin};
  end
  assign sin_s = sync_q[1];
`else
  assign sin_s = sin;
`endif

  // Serial CRC-4, x^4+x+1, init 0, message processed MSB first.
  function automatic logic [3:0] crc4(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          is_ctl_q, is_ctl_d;
  logic [63:0]   shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic          valid_q, valid_d, err_data_q, err_data_d, err_crc_q, err_crc_d;
  logic          err_op_q, err_op_d, err_frame_q, err_frame_d;

  logic [2:0] ctl_op;
  logic [3:0] ctl_crc, crc_calc;

  assign ctl_op   = byte_q[6:4];
  assign ctl_crc  = byte_q[3:0];
  assign crc_calc = crc4({shreg_q, 1'b1, ctl_op});

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_d      = byte_q;
    is_ctl_d    = is_ctl_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    valid_d     = 1'b0;
    err_data_d  = 1'b0;
    err_crc_d   = 1'b0;
    err_op_d    = 1'b0;
    err_frame_d = 1'b0;

    unique case (state_q)
      IDLE: if (!sin_s) state_d = TYPE;
      TYPE: begin
        is_ctl_d  = sin_s;
        bit_cnt_d = '0;
        state_d   = PAYLOAD;
      end
      PAYLOAD: begin
        byte_d    = {sin_s, byte_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = STOP;
      end
      STOP: begin
        state_d = IDLE;
        if (!sin_s) begin
          err_frame_d = 1'b1;
          cnt_d       = '0;
        end else if (!is_ctl_q) begin
          shreg_d = {shreg_q[55:0], byte_q};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          // Opcodes 000/001/100/101 are exactly those with bit 1 clear.
          if (cnt_q != CNT_FULL)       err_data_d = 1'b1;
          else if (crc_calc != ctl_crc) err_crc_d  = 1'b1;
          else if (ctl_op[1])           err_op_d   = 1'b1;
          else begin
            valid_d = 1'b1;
            a_d     = shreg_q[31:0];
            b_d     = shreg_q[63:32];
            op_d    = ctl_op;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      byte_q      <= '0;
      is_ctl_q    <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      valid_q     <= 1'b0;
      err_data_q  <= 1'b0;
      err_crc_q   <= 1'b0;
      err_op_q    <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_q      <= byte_d;
      is_ctl_q    <= is_ctl_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      valid_q     <= valid_d;
      err_data_q  <= err_data_d;
      err_crc_q   <= err_crc_d;
      err_op_q    <= err_op_d;
      err_frame_q <= err_frame_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign valid     = valid_q;
  assign err_data  = err_data_q;
  assign err_crc   = err_crc_q;
  assign err_op    = err_op_q;
  assign err_frame = err_frame_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Randomized self-checking bench for mtm_alu_deserializer: a packet-level model predicts
// each CTL outcome; a negedge monitor matches every output pulse against the expectation queue.
module tb_mtm_alu_deserializer;

  localparam int N_DATA = 8;
  localparam int N_RAND = 500;

  localparam logic [4:0] P_VALID = 5'b10000;
  localparam logic [4:0] P_DATA  = 5'b01000;
  localparam logic [4:0] P_CRC   = 5'b00100;
  localparam logic [4:0] P_OP    = 5'b00010;
  localparam logic [4:0] P_FRAME = 5'b00001;

  typedef struct {
    logic [4:0]  pulses;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        valid, err_data, err_crc, err_op, err_frame;

  int n_checks    = 0;
  int n_errors    = 0;
  int n_valid     = 0;
  int n_exp_valid = 0;

  exp_t       exp_q[$];
  logic [7:0] data_q[$];
  logic [31:0] hold_a = '0, hold_b = '0;
  logic [2:0]  hold_op = '0;
  logic [4:0]  mon_p;
  exp_t        mon_e;

  logic [2:0] good_ops [4] = '{3'b000, 3'b001, 3'b100, 3'b101};

  mtm_alu_deserializer #(.N_DATA(N_DATA)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .a(a), .b(b), .op(op), .valid(valid),
    .err_data(err_data), .err_crc(err_crc), .err_op(err_op), .err_frame(err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // CRC as the remainder of M(x)*x^4 divided by x^4+x+1 (polynomial long division).
  function automatic logic [3:0] model_crc(input logic [67:0] m);
    logic [71:0] r;
    r = {m, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  task automatic send_bit(input logic v);
    @(negedge clk);
    sin = v;
  endtask

  task automatic send_packet(input logic is_ctl, input logic [7:0] pl, input logic stop);
    send_bit(1'b0);
    send_bit(is_ctl);
    for (int i = 0; i < 8; i++) send_bit(pl[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_data(input logic [7:0] v);
    data_q.push_back(v);
    send_packet(1'b0, v, 1'b1);
  endtask

  task automatic send_bad_stop(input logic [7:0] v);
    exp_t e;
    e.pulses = P_FRAME; e.a = '0; e.b = '0; e.op = '0;
    exp_q.push_back(e);
    data_q.delete();
    send_packet(1'b0, v, 1'b0);
  endtask

  task automatic send_ctl(input logic [2:0] o, input logic [3:0] crc_xor);
    exp_t e;
    logic [63:0] d;
    logic [3:0]  good, sent;
    d = '0;
    foreach (data_q[i]) d = {d[55:0], data_q[i]};
    good = model_crc({d, 1'b1, o});
    sent = good ^ crc_xor;
    e.a = d[31:0]; e.b = d[63:32]; e.op = o;
    if (data_q.size() != N_DATA)                        e.pulses = P_DATA;
    else if (sent != good)                              e.pulses = P_CRC;
    else if (!(o inside {3'b000, 3'b001, 3'b100, 3'b101})) e.pulses = P_OP;
    else begin
      e.pulses = P_VALID;
      n_exp_valid++;
    end
    exp_q.push_back(e);
    data_q.delete();
    send_packet(1'b1, {1'b0, o, sent}, 1'b1);
  endtask

  task automatic send_frame(input logic [31:0] av, input logic [31:0] bv,
                            input logic [2:0] o, input logic [3:0] crc_xor);
    logic [63:0] v;
    v = {bv, av};
    for (int i = 0; i < N_DATA; i++) send_data(v[63 - 8*i -: 8]);
    send_ctl(o, crc_xor);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_p = {valid, err_data, err_crc, err_op, err_frame};
      if (mon_p != 5'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected pulse", 64'(mon_p), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse kind", 64'(mon_p), 64'(mon_e.pulses));
          if (mon_e.pulses == P_VALID) begin
            hold_a  = mon_e.a;
            hold_b  = mon_e.b;
            hold_op = mon_e.op;
            n_valid++;
          end
          check("a", 64'(a), 64'(hold_a));
          check("b", 64'(b), 64'(hold_b));
          check("op", 64'(op), 64'(hold_op));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset a/b", {a, b}, 64'(0));
    check("reset pulses/op", 64'({op, valid, err_data, err_crc, err_op, err_frame}), 64'(0));
    rst_n = 1'b1;
    idle(2);

    // Extreme operands for every legal opcode, with explicit latency and pulse-width checks.
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 4; k++) begin
        if (s == 0) send_frame(32'hFFFF_FFFF, 32'h0000_0000, good_ops[k], 4'h0);
        else        send_frame(32'h0000_0000, 32'hFFFF_FFFF, good_ops[k], 4'h0);
        @(negedge clk);
        check("valid latency", 64'(valid), 64'(1));
        check("no error with valid", 64'({err_data, err_crc, err_op, err_frame}), 64'(0));
        sin = 1'b1;
        @(negedge clk);
        check("valid width", 64'(valid), 64'(0));
      end
    end

    // Wrong DATA counts, then recovery.
    for (int i = 0; i < 7; i++) send_data(8'($urandom));
    send_ctl(3'b000, 4'h0);
    for (int i = 0; i < 9; i++) send_data(8'($urandom));
    send_ctl(3'b001, 4'h0);
    idle(2);
    send_ctl(3'b000, 4'h0);
    send_frame($urandom, $urandom, 3'b100, 4'h0);

    // CRC and opcode errors.
    send_frame($urandom, $urandom, 3'b001, 4'b0001);
    send_frame($urandom, $urandom, 3'b010, 4'h0);
    send_frame($urandom, $urandom, 3'b101, 4'h0);

    // Frame error on the 4th DATA packet, then recovery.
    for (int i = 0; i < 3; i++) send_data(8'($urandom));
    send_bad_stop(8'($urandom));
    idle(3);
    send_frame($urandom, $urandom, 3'b000, 4'h0);
    idle(3);

    // Asynchronous reset in the middle of the 5th DATA packet's payload.
    for (int i = 0; i < 4; i++) send_data(8'($urandom));
    send_bit(1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid-packet reset a/b", {a, b}, 64'(0));
    check("mid-packet reset pulses/op",
          64'({op, valid, err_data, err_crc, err_op, err_frame}), 64'(0));
    check("no pulse pending at reset", 64'(exp_q.size()), 64'(0));
    data_q.delete();
    hold_a = '0; hold_b = '0; hold_op = '0;
    sin = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_frame(32'h1234_5678, 32'h9ABC_DEF0, 3'b101, 4'h0);

    // Back-to-back random legal transactions.
    for (int t = 0; t < N_RAND; t++)
      send_frame($urandom, $urandom, good_ops[$urandom_range(0, 3)], 4'h0);

    idle(6);
    check("pulses outstanding", 64'(exp_q.size()), 64'(0));
    check("valid pulse count", 64'(n_valid), 64'(n_exp_valid));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
